// File: rtl/dropout_sequencer_if.sv
// rtl/dropout_sequencer_if.sv - beat handshake bundle for the dropout sequencer
//
// Purpose: groups the input and output beat handshakes of dropout_sequencer.
// Signals:
//   in_valid/in_ready     input handshake
//   in_data               packed beat, lane i = bits [i*DW +: DW]
//   in_last               end-of-sample marker
//   out_valid/out_ready   output handshake
//   out_data, out_mask    masked beat and its keep mask (1 = kept)
//   out_last              end-of-sample marker of the held beat
// Modports: master = beat source/sink around the block, slave = the block.
interface dropout_sequencer_if #(
  parameter int LANES = 8,
  parameter int DW    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic [LANES-1:0]      out_mask;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last
  );
endinterface

// File: rtl/dropout_sequencer.sv
// rtl/dropout_sequencer.sv - LFSR-driven per-lane dropout mask applied to a beat stream
//
// Purpose: generates one keep-mask bit per cycle from a 16-bit Fibonacci LFSR
// into a shadow register, hands a full mask to cur_mask, and applies it to one
// accepted beat. With enable=0 beats pass through unmasked and the generator
// is frozen.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   enable           1 = training (dropout applied), 0 = inference
//   threshold        lane dropped when the LFSR low byte is below it
//   seed, seed_load  reload the LFSR (seed 0 falls back to SEED)
//   bus              dropout_sequencer_if.slave beat handshakes
//   drop_count       dropped-lane statistic
// Optional feature: define DROPOUT_STATS_EN to build the saturating
// drop_count counter; otherwise drop_count is tied to 0.
module dropout_sequencer #(
  parameter int          LANES = 8,
  parameter int          DW    = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           threshold,
  input  logic [15:0]          seed,
  input  logic                 seed_load,
  dropout_sequencer_if.slave   bus,
  output logic [15:0]          drop_count
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [15:0]         lfsr_q, lfsr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LANES-1:0]    shadow_q, shadow_d;
  logic                shadow_full_q, shadow_full_d;
  logic [LANES-1:0]    cur_mask_q, cur_mask_d;
  logic                cur_valid_q, cur_valid_d;
  logic                out_valid_q, out_valid_d;
  logic [LANES*DW-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]    out_mask_q, out_mask_d;
  logic                out_last_q, out_last_d;

  logic                lfsr_fb;
  logic                gen_en;
  logic                xfer_en;
  logic                out_free;
  logic                in_ready_c;
  logic                accept;
  logic [LANES-1:0]    eff_mask;

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // The generator only moves in training mode.
  assign gen_en  = enable && !shadow_full_q;
  assign xfer_en = enable && shadow_full_q && !cur_valid_q;

  assign out_free   = !out_valid_q || bus.out_ready;
  // Gated by reset so the handshake reads idle while reset is held.
  assign in_ready_c = !reset && (enable ? (cur_valid_q && out_free) : out_free);
  assign accept     = bus.in_valid && in_ready_c;
  assign eff_mask   = enable ? cur_mask_q : {LANES{1'b1}};

  always_comb begin
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    cur_mask_d    = cur_mask_q;
    cur_valid_d   = cur_valid_q;

    if (seed_load) begin
      // Reseed wins over generation and transfer; partial and pending masks
      // are thrown away so every later mask comes from the new seed.
      lfsr_d        = (seed == 16'd0) ? SEED : seed;
      cnt_d         = '0;
      shadow_full_d = 1'b0;
      cur_valid_d   = 1'b0;
    end else begin
      if (gen_en) begin
        shadow_d[cnt_q] = (lfsr_q[7:0] >= threshold);
        lfsr_d          = {lfsr_fb, lfsr_q[15:1]};
        if (cnt_q == CW'(LANES - 1)) begin
          cnt_d         = '0;
          shadow_full_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Transfer needs an empty cur_mask and a training accept needs a full
      // one, so the two never coincide.
      if (xfer_en) begin
        cur_mask_d    = shadow_q;
        cur_valid_d   = 1'b1;
        shadow_full_d = 1'b0;
      end
      if (accept && enable) begin
        cur_valid_d = 1'b0;
      end
    end
  end

  // Output register ignores seed_load; an accept on a reseed edge still uses
  // the mask that was current before the reseed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_mask_d  = eff_mask;
      out_last_d  = bus.in_last;
      for (int i = 0; i < LANES; i++) begin
        out_data_d[i*DW +: DW] = eff_mask[i] ? bus.in_data[i*DW +: DW] : '0;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= SEED;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      cur_mask_q    <= '0;
      cur_valid_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      cur_mask_q    <= cur_mask_d;
      cur_valid_q   <= cur_valid_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_mask_q    <= out_mask_d;
      out_last_q    <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;

`ifdef DROPOUT_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] drop_zeros;
  logic [16:0] drop_sum;

  always_comb begin
    drop_zeros = '0;
    for (int i = 0; i < LANES; i++) begin
      drop_zeros = drop_zeros + {15'd0, ~eff_mask[i]};
    end
    drop_sum     = {1'b0, drop_count_q} + {1'b0, drop_zeros};
    drop_count_d = drop_count_q;
    if (accept) begin
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: doc/dropout_sequencer.md
DROPOUT_SEQUENCER -- requirements
Module: dropout_sequencer

Interface
REQ-001 Parameter: LANES, 8, neurons per beat.
REQ-002 Parameter: DW, 8, bits per neuron value.
REQ-003 Parameter: SEED, 16'hACE1, LFSR reset and fallback seed.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: enable  in  1  1 = training (apply dropout), 0 = inference (pass-through).
REQ-008 Port: threshold  in  8  drop probability = threshold/256.
REQ-009 Port: seed  in  16  LFSR seed value.
REQ-010 Port: seed_load  in  1  single-cycle seed load strobe.
REQ-011 Port: in_valid  in  1; in_ready  out  1  input handshake.
REQ-012 Port: in_data  in  LANES*DW  packed beat, lane i = bits [i*DW +: DW].
REQ-013 Port: in_last  in  1  end-of-sample marker, passed through unchanged.
REQ-014 Port: out_valid  out  1; out_ready  in  1  output handshake.
REQ-015 Port: out_data  out  LANES*DW; out_mask  out  LANES (1 = kept); out_last  out  1.
REQ-016 Port: drop_count  out  16  dropped-lane statistic.

Function
REQ-017 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances exactly one step per generation cycle.
REQ-018 Generation: lane counter 0..7. Each generation cycle writes shadow bit[count] = (lfsr[7:0] < threshold) ? 0 : 1, using the threshold sampled that cycle.
REQ-019 Generation runs only while enable=1 and shadow is not full. Shadow is full after 8 generation cycles.
REQ-020 Mask transfer: when shadow is full and cur_mask is empty, shadow moves to cur_mask on the next edge. Shadow then empties and generation restarts on the following cycle.
REQ-021 Training-mode in_ready = cur_valid && (!out_valid || out_ready).
REQ-022 Inference-mode in_ready = !out_valid || out_ready.
REQ-023 On accept (in_valid && in_ready), the output register loads on that edge (latency 1):
  - out_data lane i = mask[i] ? in lane i : 0
  - out_mask = mask; out_last = in_last
  - mask = cur_mask in training mode, all ones in inference mode.
REQ-024 In training mode, each accepted beat consumes cur_mask (cur_valid cleared). One mask is used per beat; masks are never reused.
REQ-025 out_valid, out_data, out_mask and out_last hold stable while out_valid && !out_ready.
REQ-026 out_valid clears on an out_ready edge with no new accept. A simultaneous drain and accept keeps out_valid=1 with the new data.
REQ-027 In inference mode, the LFSR, lane counter, shadow and cur_mask are frozen. Generation resumes from the frozen state when enable returns to 1.
REQ-028 seed_load has priority over all other activity. On that edge:
  - lfsr <= (seed==0 ? SEED : seed)
  - lane counter <= 0
  - shadow and cur_mask are invalidated
  - the output register is unaffected
  - an accept in the same cycle is still performed with the old cur_mask.
REQ-029 The LFSR never holds zero.
REQ-030 First-mask timing: with enable=1 from reset release, in_ready first asserts after the 9th edge (8 generation edges + 1 transfer edge).
REQ-031 Steady-state training throughput is at most one beat per 9 cycles.

Reset
REQ-032 On reset:
  - lfsr=SEED, lane counter=0, shadow and cur_mask empty
  - out_valid=0, out_data=0, out_mask=0, out_last=0
  - in_ready=0, drop_count=0.
REQ-033 Reset during a transfer or generation discards all partial masks; the next beat uses a mask generated entirely after reset.

Configuration
REQ-034 Macro DROPOUT_STATS_EN, when defined:
  - drop_count increments on every output-register load by the number of zero bits in the loaded mask
  - it saturates at 16'hFFFF.
REQ-035 Without DROPOUT_STATS_EN, drop_count is constant 0 and no counter logic is built.

Verification
REQ-036 threshold=0, enable=1, 4 beats of 0x0807060504030201 -> out_mask=0xFF and out_data equal to input on every beat.
REQ-037 threshold=255, enable=1 -> each out_mask bit is 0 unless its lfsr byte was 0xFF; dropped lanes read 0x00.
REQ-038 seed_load with seed=0x1234, capture 3 masks; repeat the load and capture -> identical mask sequence. seed=0 -> same sequence as SEED.
REQ-039 enable=0, out_ready=1, back-to-back beats -> in_ready=1 every cycle, out_mask=0xFF, LFSR unchanged.
REQ-040 out_ready held 0 for 5 cycles with out_valid=1 -> out_* stable and in_ready=0; release -> exactly one beat drained.
REQ-041 DROPOUT_STATS_EN, threshold=128, 100 beats -> drop_count equals the sum of zero bits in the observed out_mask values.
